// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard pad: scancode set 2 markers,
// active-low Gigatron gamepad codes and the make/break decoder state.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_END    = 8'h69;

    // One cleared bit per button, as the gamepad shifter expects.
    typedef enum logic [7:0] {
        PAD_RIGHT  = 8'hFE,
        PAD_LEFT   = 8'hFD,
        PAD_DOWN   = 8'hFB,
        PAD_UP     = 8'hF7,
        PAD_START  = 8'hEF,
        PAD_SELECT = 8'hDF,
        PAD_B      = 8'hBF,
        PAD_A      = 8'h7F
    } pad_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } dec_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 line receiver: synchronises and deglitches the pins, assembles
// 11-bit frames on falling clock edges and discards stalled partial frames.
module ps2_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [7:0]  scancode,
    output logic        strobe,
    output logic        error,
    output logic [3:0]  bitcnt,
    output logic [10:0] sr
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   sr_q, sr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          strobe_q, strobe_d;
    logic          error_q, error_d;
    logic          fall_c;
    logic [10:0]   frame_c;

    // Pins idle high, so the synchronisers and filter come out of reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            tmo_q      <= '0;
            scancode_q <= '0;
            strobe_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            bitcnt_q   <= bitcnt_d;
            sr_q       <= sr_d;
            tmo_q      <= tmo_d;
            scancode_q <= scancode_d;
            strobe_q   <= strobe_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        filt_d     = filt_q;
        fcnt_d     = '0;
        bitcnt_d   = bitcnt_q;
        sr_d       = sr_q;
        tmo_d      = tmo_q;
        scancode_d = scancode_q;
        strobe_d   = 1'b0;
        error_d    = 1'b0;
        frame_c    = {dat_sync_q[1], sr_q[10:1]};

        // Level flips only after FILTER_LEN consecutive disagreeing samples.
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        fall_c = filt_q & ~filt_d;

        if (fall_c) begin
            sr_d  = frame_c;
            tmo_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                if (!frame_c[0] && frame_c[10] && (^frame_c[9:1])) begin
                    strobe_d   = 1'b1;
                    scancode_d = frame_c[8:1];
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                bitcnt_d = 4'd0;
                tmo_d    = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign scancode = scancode_q;
    assign strobe   = strobe_q;
    assign error    = error_q;
    assign bitcnt   = bitcnt_q;
    assign sr       = sr_q;

endmodule

// File: rtl/ps2_keyboard_pad.sv
// PS/2 keyboard to Gigatron input byte: decodes set 2 make/break sequences,
// translates key presses and offers the byte through a ready/ack handshake.
module ps2_keyboard_pad
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        clk1,
    input  logic        clk2,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [7:0]  key_code,
    output logic        key_ready,
    input  logic        key_ack
);

    logic [7:0]  rx_code;
    logic        rx_stb, rx_err;
    logic [3:0]  rx_bitcnt;
    logic [10:0] rx_sr;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .scancode(rx_code),
        .strobe  (rx_stb),
        .error   (rx_err),
        .bitcnt  (rx_bitcnt),
        .sr      (rx_sr)
    );

    // Returns {hit, byte}; letters are uppercased while shift is held.
    function automatic logic [8:0] translate(input logic [7:0] sc, input logic ext,
                                             input logic shift);
        logic [7:0] ch;
        logic       hit;
        ch  = 8'h00;
        hit = 1'b1;
        if (ext) begin
            case (sc)
                SC_RIGHT: ch = PAD_RIGHT;
                SC_LEFT:  ch = PAD_LEFT;
                SC_DOWN:  ch = PAD_DOWN;
                SC_UP:    ch = PAD_UP;
                SC_HOME:  ch = PAD_START;
                SC_END:   ch = PAD_SELECT;
                default:  hit = 1'b0;
            endcase
        end else begin
            case (sc)
                8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
                8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
                8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
                8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
                8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
                8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
                8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
                8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
                8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
                8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
                8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
                8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
                8'h46: ch = 8'h39;
                8'h29: ch = 8'h20;  8'h5A: ch = 8'h0A;  8'h66: ch = 8'h7F;
                8'h0D: ch = 8'h09;  8'h76: ch = 8'h1B;
                default: hit = 1'b0;
            endcase
            if (shift && ch >= 8'h61 && ch <= 8'h7A) begin
                ch = ch - 8'h20;
            end
        end
        return {hit, ch};
    endfunction

    logic [1:0] clk1_sync_q, clk2_sync_q, ack_sync_q;
    logic       ack_prev_q;
    dec_state_e state_q, state_d;
    logic       shift_q, shift_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ready_q, key_ready_d;
    logic [7:0] last_sc_q, last_sc_d;
    logic [7:0] frm_cnt_q, frm_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [15:0] dbg_q, dbg_d;
    logic       ack_rise_c, in_ext_c, in_brk_c;
    logic [8:0] tr_c;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk1_sync_q <= '0;
            clk2_sync_q <= '0;
            ack_sync_q  <= '0;
            ack_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= 1'b0;
            key_code_q  <= 8'hFF;
            key_ready_q <= 1'b0;
            last_sc_q   <= '0;
            frm_cnt_q   <= '0;
            err_cnt_q   <= '0;
            dbg_q       <= '0;
        end else begin
            clk1_sync_q <= {clk1_sync_q[0], clk1};
            clk2_sync_q <= {clk2_sync_q[0], clk2};
            ack_sync_q  <= {ack_sync_q[0], key_ack};
            ack_prev_q  <= ack_sync_q[1];
            state_q     <= state_d;
            shift_q     <= shift_d;
            key_code_q  <= key_code_d;
            key_ready_q <= key_ready_d;
            last_sc_q   <= last_sc_d;
            frm_cnt_q   <= frm_cnt_d;
            err_cnt_q   <= err_cnt_d;
            dbg_q       <= dbg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        key_code_d  = key_code_q;
        key_ready_d = key_ready_q;
        last_sc_d   = last_sc_q;
        frm_cnt_d   = frm_cnt_q;
        err_cnt_d   = err_cnt_q;
        dbg_d       = dbg_q;
        ack_rise_c  = ack_sync_q[1] & ~ack_prev_q;
        in_ext_c    = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
        in_brk_c    = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
        tr_c        = translate(rx_code, in_ext_c, shift_q);

        // Ack clears first so a make in the same cycle still leaves ready set.
        if (ack_rise_c) begin
            key_ready_d = 1'b0;
        end
        if (rx_err) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (rx_stb) begin
            last_sc_d = rx_code;
            frm_cnt_d = frm_cnt_q + 8'd1;
            if (rx_code == SC_EXT) begin
                state_d = in_brk_c ? ST_EXTBRK : ST_EXT;
            end else if (rx_code == SC_BRK) begin
                state_d = in_ext_c ? ST_EXTBRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                if (!in_ext_c && (rx_code == SC_LSHIFT || rx_code == SC_RSHIFT)) begin
                    shift_d = ~in_brk_c;
                end else if (!in_brk_c && tr_c[8]) begin
                    key_code_d  = tr_c[7:0];
                    key_ready_d = 1'b1;
                end
            end
        end

        case (dbg_sel)
            3'd0: dbg_d = {last_sc_q, key_code_q};
            3'd1: dbg_d = {frm_cnt_q, err_cnt_q};
            3'd2: dbg_d = {5'b0, state_q, shift_q, rx_bitcnt, clk1_sync_q[1],
                           clk2_sync_q[1], key_ready_q, ack_sync_q[1]};
            3'd3: dbg_d = {5'b0, rx_sr};
            default: dbg_d = 16'hDEAD;
        endcase
    end

    assign key_code  = key_code_q;
    assign key_ready = key_ready_q;
    assign dbg       = dbg_q;

endmodule

// File: tb/tb_ps2_keyboard_pad.sv
// Bench for ps2_keyboard_pad: directed scenarios plus random keystrokes
// compared against a table-driven model of keyboard semantics.
module tb_ps2_keyboard_pad;

    localparam int HALF = 25;

    logic        clk, rst_n, clk1, clk2, ps2_clk, ps2_dat, key_ack, key_ready;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg;
    logic [7:0]  key_code;

    ps2_keyboard_pad dut (
        .CLOCK_50(clk), .reset_n(rst_n), .clk1(clk1), .clk2(clk2),
        .dbg_sel(dbg_sel), .dbg(dbg), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .key_code(key_code), .key_ready(key_ready), .key_ack(key_ack)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of what the keyboard user should see.
    logic [7:0] lo_map [256];
    logic       lo_ok  [256];
    logic       is_let [256];
    logic [7:0] ex_map [256];
    logic       ex_ok  [256];
    logic [7:0] pool [$];
    logic [7:0] m_code, m_frm, m_err;
    logic       m_ready, m_shift, m_ext, m_brk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_maps();
        logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
        logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        logic [7:0] oth_sc [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
        logic [7:0] oth_ch [5]  = '{8'h20, 8'h0A, 8'h7F, 8'h09, 8'h1B};
        logic [7:0] ext_sc [6]  = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h6C, 8'h69};
        logic [7:0] ext_ch [6]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
        for (int i = 0; i < 256; i++) begin
            lo_ok[i] = 1'b0; ex_ok[i] = 1'b0; is_let[i] = 1'b0;
            lo_map[i] = 8'h00; ex_map[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) begin
            lo_map[let_sc[i]] = 8'h61 + 8'(i); lo_ok[let_sc[i]] = 1'b1;
            is_let[let_sc[i]] = 1'b1; pool.push_back(let_sc[i]);
        end
        for (int i = 0; i < 10; i++) begin
            lo_map[dig_sc[i]] = 8'h30 + 8'(i); lo_ok[dig_sc[i]] = 1'b1; pool.push_back(dig_sc[i]);
        end
        for (int i = 0; i < 5; i++) begin
            lo_map[oth_sc[i]] = oth_ch[i]; lo_ok[oth_sc[i]] = 1'b1; pool.push_back(oth_sc[i]);
        end
        for (int i = 0; i < 6; i++) begin
            ex_map[ext_sc[i]] = ext_ch[i]; ex_ok[ext_sc[i]] = 1'b1; pool.push_back(ext_sc[i]);
        end
        for (int i = 0; i < 6; i++) begin
            pool.push_back(8'hE0); pool.push_back(8'hF0);
        end
        pool.push_back(8'h12); pool.push_back(8'h59);
    endtask

    task automatic model_reset();
        m_code = 8'hFF; m_ready = 1'b0; m_shift = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        m_frm = 8'h00; m_err = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] c);
        m_frm = m_frm + 8'd1;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_ext && (c == 8'h12 || c == 8'h59)) m_shift = !m_brk;
            else if (!m_brk) begin
                if (m_ext && ex_ok[c]) begin
                    m_code = ex_map[c]; m_ready = 1'b1;
                end else if (!m_ext && lo_ok[c]) begin
                    m_code = (m_shift && is_let[c]) ? lo_map[c] - 8'h20 : lo_map[c];
                    m_ready = 1'b1;
                end
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            wait_cyc(12);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            wait_cyc(13);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ bad, c, 1'b0};
        send_bits(f, 11);
        wait_cyc(20);
    endtask

    task automatic send_key(input logic [7:0] c);
        send_frame(c, 1'b0);
        model_frame(c);
        check($sformatf("code_after_%02h", c), 32'(key_code), 32'(m_code));
        check($sformatf("ready_after_%02h", c), 32'(key_ready), 32'(m_ready));
    endtask

    task automatic read_dbg(input logic [2:0] sel, output logic [15:0] v);
        dbg_sel = sel;
        wait_cyc(2);
        v = dbg;
    endtask

    task automatic check_counters(input string tag);
        logic [15:0] v;
        read_dbg(3'd1, v);
        check(tag, 32'(v), 32'({m_frm, m_err}));
    endtask

    task automatic do_ack();
        int n;
        key_ack = 1'b1;
        n = 0;
        while (key_ready !== 1'b0 && n < 3) begin
            wait_cyc(1);
            n++;
        end
        check("ack_clears_ready", 32'(key_ready), 32'(0));
        m_ready = 1'b0;
        wait_cyc(4);
        key_ack = 1'b0;
        wait_cyc(4);
        check("code_held_after_ack", 32'(key_code), 32'(m_code));
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  c;
        int          r;
        init_maps();
        model_reset();
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; key_ack = 1'b0;
        clk1 = 1'b0; clk2 = 1'b0; dbg_sel = 3'd0;
        wait_cyc(3);
        check("reset_code", 32'(key_code), 32'hFF);
        check("reset_ready", 32'(key_ready), 32'(0));
        check("reset_dbg", 32'(dbg), 32'(0));
        rst_n = 1'b1;
        wait_cyc(5);

        // press then release of 'a'
        send_key(8'h1C);
        send_key(8'hF0);
        send_key(8'h1C);
        read_dbg(3'd0, v);
        check("dbg_last_and_code", 32'(v), 32'h1C61);
        do_ack();

        // shifted letter, then ack
        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12);
        check("shift_upper_a", 32'(key_code), 32'h41);
        do_ack();

        // extended arrows
        send_key(8'hE0); send_key(8'h75);
        check("up_pad", 32'(key_code), 32'hF7);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        send_key(8'hE0); send_key(8'h6B);
        check("left_pad", 32'(key_code), 32'hFD);
        do_ack();
        check_counters("counters_good");

        // parity error then a good frame
        send_frame(8'h1C, 1'b1);
        m_err = m_err + 8'd1;
        check("parity_no_ready", 32'(key_ready), 32'(0));
        check_counters("counters_parity");
        send_key(8'h29);
        check("space_after_err", 32'(key_code), 32'h20);

        // stalled partial frame is dropped by the timeout
        send_bits(11'h7FE, 4);
        wait_cyc(6000);
        send_key(8'h5A);
        check("enter_after_timeout", 32'(key_code), 32'h0A);
        check_counters("counters_timeout");

        // short clock glitches are filtered out
        for (int k = 0; k < 4; k++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        read_dbg(3'd2, v);
        check("glitch_bitcnt", 32'(v[7:4]), 32'(0));
        check_counters("counters_glitch");

        // latest make wins without ack
        send_key(8'h16); send_key(8'h1E);
        check("overwrite_code", 32'(key_code), 32'h32);
        check("overwrite_ready", 32'(key_ready), 32'(1));

        clk1 = 1'b1; clk2 = 1'b0;
        wait_cyc(4);
        read_dbg(3'd2, v);
        check("dbg_phase_bits", 32'(v[3:2]), 32'(2'b10));
        read_dbg(3'd5, v);
        check("dbg_dead", 32'(v), 32'hDEAD);
        do_ack();

        // random keystrokes against the model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                do_ack();
            end else if (r < 13) begin
                c = 8'($urandom_range(0, 255));
                send_frame(c, 1'b1);
                m_err = m_err + 8'd1;
                check("rand_bad_ready", 32'(key_ready), 32'(m_ready));
            end else if (r < 35) begin
                send_key(8'($urandom_range(0, 255)));
            end else begin
                send_key(pool[$urandom_range(0, pool.size() - 1)]);
            end
            if (it % 10 == 9) check_counters("rand_counters");
        end

        // reset in the middle of a frame
        send_key(8'h1C);
        send_bits(11'h3AA, 5);
        rst_n = 1'b0;
        #2;
        check("midreset_code", 32'(key_code), 32'hFF);
        check("midreset_ready", 32'(key_ready), 32'(0));
        check("midreset_dbg", 32'(dbg), 32'(0));
        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        check_counters("counters_after_reset");
        read_dbg(3'd2, v);
        check("bitcnt_after_reset", 32'(v[7:4]), 32'(0));
        send_key(8'h1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
